vc_rr_stream_mux: RTL and testbench

Parametrised N-input, val/rdy stream multiplexer with a registered output. It selects among up to eight input streams, either by round-robin arbitration or by an externally forced select, and forwards the winner through a one-entry output buffer. Each output message is tagged with its source index. It sits where the combinational vc_MuxN family cannot be used because sources are latency-insensitive streams, for example response merging in front of a memory port or a writeback port.

---
 rtl/vc_rr_stream_mux.sv | 107 ++++++++++
 tb/tb_vc_rr_stream_mux.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_rr_stream_mux.sv
// vc_rr_stream_mux: N-input val/rdy stream multiplexer with a one-entry
// registered output buffer. The winner is chosen by round-robin arbitration
// (mode=0) or by an externally forced index (mode=1). Each buffered message
// is tagged with the index of the input that supplied it.
//
// Ports:
//   clk        clock, rising-edge state updates
//   reset      asynchronous active-high reset
//   in_val     per-input valid            in_rdy   per-input ready (comb, one-hot or zero)
//   in_msg     flattened input messages, input i at [i*p_nbits +: p_nbits]
//   mode       0 = round-robin, 1 = forced select
//   force_sel  input index used when mode=1
//   out_val    output buffer holds a message
//   out_rdy    downstream ready
//   out_msg    buffered message           out_src  source index of out_msg
module vc_rr_stream_mux #(
   parameter int unsigned p_nbits     = 32,
   parameter int unsigned p_ninputs   = 4,
   parameter int unsigned p_sel_nbits = $clog2(p_ninputs)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [p_ninputs-1:0]           in_val,
   output logic [p_ninputs-1:0]           in_rdy,
   input  logic [p_ninputs*p_nbits-1:0]   in_msg,
   input  logic                           mode,
   input  logic [p_sel_nbits-1:0]         force_sel,
   output logic                           out_val,
   input  logic                           out_rdy,
   output logic [p_nbits-1:0]             out_msg,
   output logic [p_sel_nbits-1:0]         out_src
);

   localparam int unsigned LAST_IDX = p_ninputs - 1;

   logic [p_sel_nbits-1:0] ptr;
   logic [p_sel_nbits-1:0] ptr_nxt;
   logic [p_ninputs-1:0]   grant;
   logic [p_sel_nbits-1:0] gidx;
   logic                   gany;
   logic [p_nbits-1:0]     sel_msg;
   logic                   enq_en;
   logic                   in_xfer;

   // Buffer can take a new message when empty or being drained this cycle
   assign enq_en  = !out_val || out_rdy;
   assign in_xfer = gany && enq_en && !reset;

   // Held low during reset so no source sees a handshake it cannot complete
   assign in_rdy  = (enq_en && !reset) ? grant : '0;

   // Grant selection: forced index, or first valid input scanning from ptr
   always_comb begin
      grant = '0;
      gidx  = '0;
      gany  = 1'b0;
      if (mode) begin
         // Loop over legal indices only, so an out-of-range force_sel grants nothing
         for (int i = 0; i < int'(p_ninputs); i++) begin
            if (force_sel == p_sel_nbits'(i) && in_val[i]) begin
               grant[i] = 1'b1;
               gidx     = p_sel_nbits'(i);
               gany     = 1'b1;
            end
         end
      end else begin
         for (int k = 0; k < int'(p_ninputs); k++) begin
            if (!gany && in_val[p_sel_nbits'((int'(ptr) + k) % int'(p_ninputs))]) begin
               grant[p_sel_nbits'((int'(ptr) + k) % int'(p_ninputs))] = 1'b1;
               gidx = p_sel_nbits'((int'(ptr) + k) % int'(p_ninputs));
               gany = 1'b1;
            end
         end
      end
   end

   // Message mux driven by the one-hot grant
   always_comb begin
      sel_msg = '0;
      for (int i = 0; i < int'(p_ninputs); i++) begin
         if (grant[i]) sel_msg = in_msg[i*int'(p_nbits) +: p_nbits];
      end
   end

   // Explicit wrap: gidx+1 in p_sel_nbits bits is wrong for non-power-of-2 counts
   assign ptr_nxt = (gidx == p_sel_nbits'(LAST_IDX)) ? '0 : gidx + 1'b1;

   // Output buffer and round-robin pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_val <= 1'b0;
         out_msg <= '0;
         out_src <= '0;
         ptr     <= '0;
      end else begin
         if (in_xfer) begin
            out_val <= 1'b1;
            out_msg <= sel_msg;
            out_src <= gidx;
            if (!mode) ptr <= ptr_nxt;
         end else if (out_val && out_rdy) begin
            out_val <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vc_rr_stream_mux.sv
// Bench for vc_rr_stream_mux: a 4-input and a 3-input instance share one
// stimulus; both are compared every cycle to a behavioural model, plus a
// hand-derived vector table and directed reset / wrap sequences.
module tb_vc_rr_stream_mux;

   localparam int unsigned NB = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  in_val;
   logic [31:0] in_msg;
   logic        mode;
   logic [1:0]  force_sel;
   logic        out_rdy;

   logic [3:0]  rdy4;
   logic        oval4;
   logic [7:0]  omsg4;
   logic [1:0]  osrc4;
   logic [2:0]  rdy3;
   logic        oval3;
   logic [7:0]  omsg3;
   logic [1:0]  osrc3;

   int nvec  = 0;
   int nfail = 0;
   int ncyc  = 0;

   always #5 clk = ~clk;

   vc_rr_stream_mux #(.p_nbits(NB), .p_ninputs(4)) dut4 (
      .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(rdy4), .in_msg(in_msg),
      .mode(mode), .force_sel(force_sel), .out_val(oval4), .out_rdy(out_rdy),
      .out_msg(omsg4), .out_src(osrc4));

   vc_rr_stream_mux #(.p_nbits(NB), .p_ninputs(3)) dut3 (
      .clk(clk), .reset(reset), .in_val(in_val[2:0]), .in_rdy(rdy3), .in_msg(in_msg[23:0]),
      .mode(mode), .force_sel(force_sel), .out_val(oval3), .out_rdy(out_rdy),
      .out_msg(omsg3), .out_src(osrc3));

   // Behavioural model state, index 0 = 4-input, 1 = 3-input
   int nin[2] = '{4, 3};
   int mptr[2];
   bit mval[2];
   int mmsg[2];
   int msrc[2];

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, ncyc, act, exp);
      end
   endtask

   function automatic int mgrant(input int n, input int p, input logic [3:0] v,
                                 input logic md, input int fs);
      if (md) return (fs < n && v[fs]) ? fs : -1;
      for (int k = 0; k < n; k++) begin
         if (v[(p + k) % n]) return (p + k) % n;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         mptr[d] = 0; mval[d] = 0; mmsg[d] = 0; msrc[d] = 0;
      end
   endtask

   // Compare both DUTs against the model, then advance the model by one edge
   task automatic check_cycle();
      for (int d = 0; d < 2; d++) begin
         int  g, exp_rdy, a_rdy, a_val, a_msg, a_src;
         bit  enq;
         enq = !mval[d] || out_rdy;
         g   = mgrant(nin[d], mptr[d], in_val, mode, int'(force_sel));
         exp_rdy = (!reset && enq && g >= 0) ? (1 << g) : 0;
         a_rdy = (d == 0) ? int'(rdy4)  : int'(rdy3);
         a_val = (d == 0) ? int'(oval4) : int'(oval3);
         a_msg = (d == 0) ? int'(omsg4) : int'(omsg3);
         a_src = (d == 0) ? int'(osrc4) : int'(osrc3);
         chk($sformatf("n%0d.in_rdy", nin[d]), a_rdy, exp_rdy);
         chk($sformatf("n%0d.onehot", nin[d]), int'($onehot0(a_rdy)), 1);
         chk($sformatf("n%0d.out_val", nin[d]), a_val, int'(mval[d]));
         chk($sformatf("n%0d.out_msg", nin[d]), a_msg, mmsg[d]);
         chk($sformatf("n%0d.out_src", nin[d]), a_src, msrc[d]);
         if (!reset) begin
            if (enq && g >= 0) begin
               mval[d] = 1;
               mmsg[d] = int'(in_msg[g*8 +: 8]);
               msrc[d] = g;
               if (!mode) mptr[d] = (g + 1) % nin[d];
            end else if (mval[d] && out_rdy) begin
               mval[d] = 0;
            end
         end
      end
   endtask

   // Inputs are driven at posedge+1; checks happen at the falling edge
   task automatic cyc();
      #4;
      check_cycle();
      @(posedge clk);
      #1;
      ncyc++;
   endtask

   task automatic hard_reset();
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   typedef struct {
      logic [3:0] val;
      logic       md;
      logic [1:0] fs;
      logic       ordy;
      logic [3:0] e_rdy;
      logic       e_oval;
      logic [7:0] e_msg;
      logic [1:0] e_src;
   } vec_t;

   vec_t tbl[16];

   initial begin
      // Expected values for the 4-input instance, state as seen before each edge
      tbl[0]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0};
      tbl[1]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 8'hA0, 2'd0};
      tbl[2]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 8'hA1, 2'd1};
      tbl[3]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 8'hA2, 2'd2};
      tbl[4]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 8'hA3, 2'd3};
      tbl[5]  = '{4'hF, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0};
      tbl[6]  = '{4'hF, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0};
      tbl[7]  = '{4'hF, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0};
      tbl[8]  = '{4'hF, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0};
      tbl[9]  = '{4'hF, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0};
      tbl[10] = '{4'hF, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 8'hA0, 2'd0};
      tbl[11] = '{4'h3, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
      tbl[12] = '{4'h3, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
      tbl[13] = '{4'h3, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b1, 8'hA1, 2'd1};
      tbl[14] = '{4'hF, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b0, 8'hA1, 2'd1};
      tbl[15] = '{4'hF, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 8'hA2, 2'd2};

      reset     = 1'b1;
      in_val    = '0;
      in_msg    = 32'hA3A2A1A0;
      mode      = 1'b0;
      force_sel = '0;
      out_rdy   = 1'b1;
      model_reset();
      #1;
      chk("reset.out_val", int'(oval4), 0);
      chk("reset.in_rdy", int'(rdy4), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Rotation, backpressure, forced mode, return to round-robin
      for (int r = 0; r < 16; r++) begin
         in_val    = tbl[r].val;
         mode      = tbl[r].md;
         force_sel = tbl[r].fs;
         out_rdy   = tbl[r].ordy;
         #4;
         chk($sformatf("tbl%0d.in_rdy", r),  int'(rdy4),  int'(tbl[r].e_rdy));
         chk($sformatf("tbl%0d.out_val", r), int'(oval4), int'(tbl[r].e_oval));
         chk($sformatf("tbl%0d.out_msg", r), int'(omsg4), int'(tbl[r].e_msg));
         chk($sformatf("tbl%0d.out_src", r), int'(osrc4), int'(tbl[r].e_src));
         check_cycle();
         @(posedge clk);
         #1;
         ncyc++;
      end

      // Sparse inputs on the 3-input instance: mod-3 wrap of the pointer
      hard_reset();
      mode = 1'b0; out_rdy = 1'b1; in_val = 4'b0001;
      cyc();
      in_val = 4'b0101;
      for (int s = 0; s < 3; s++) begin
         #4;
         chk($sformatf("wrap%0d.in_rdy", s), int'(rdy3), (s == 1) ? 1 : 4);
         check_cycle();
         @(posedge clk);
         #1;
         ncyc++;
      end

      // Reset asserted between edges with source 2 buffered
      hard_reset();
      in_val = 4'hF; out_rdy = 1'b1;
      for (int s = 0; s < 3; s++) cyc();
      out_rdy = 1'b0;
      #4;
      chk("midrst.pre_src", int'(osrc4), 2);
      check_cycle();
      reset = 1'b1;
      #1;
      chk("midrst.out_val", int'(oval4), 0);
      chk("midrst.out_msg", int'(omsg4), 0);
      chk("midrst.out_src", int'(osrc4), 0);
      chk("midrst.in_rdy",  int'(rdy4), 0);
      model_reset();
      #1;
      reset = 1'b0;
      #1;
      chk("midrst.first_grant", int'(rdy4), 1);
      check_cycle();
      @(posedge clk);
      #1;
      ncyc++;
      out_rdy = 1'b1;
      #4;
      chk("midrst.first_msg", int'(omsg4), 8'hA0);
      check_cycle();
      @(posedge clk);
      #1;
      ncyc++;

      // Random traffic against the model
      for (int t = 0; t < 10000; t++) begin
         in_val    = 4'($urandom);
         in_msg    = $urandom;
         out_rdy   = ($urandom_range(0, 3) != 0);
         mode      = ($urandom_range(0, 7) == 0);
         force_sel = 2'($urandom);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
